// File: rtl/otter_stall_ctrl.sv
// Pipeline sequencer for the 5-stage OTTER core: RAW-hazard bubble counting,
// taken-branch flushes and memory-busy freezes, with no forwarding paths.
module otter_stall_ctrl #(
    parameter int RF_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] de_ir,
    input  logic [31:0] ex_ir,
    input  logic [31:0] mem_ir,
    input  logic [31:0] wb_ir,
    input  logic        ex_valid,
    input  logic        mem_valid,
    input  logic        wb_valid,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_de_en,
    output logic        if_de_clear,
    output logic        de_ex_clear,
    output logic        back_en,
    output logic [1:0]  stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    // Bubbles needed when DE reads a register still being produced downstream
    localparam logic [1:0] EX_NEED  = (RF_BYPASS != 0) ? 2'd2 : 2'd3;
    localparam logic [1:0] MEM_NEED = (RF_BYPASS != 0) ? 2'd1 : 2'd2;
    localparam logic [1:0] WB_NEED  = (RF_BYPASS != 0) ? 2'd0 : 2'd1;

    logic [6:0] de_op;
    logic [4:0] de_rs1;
    logic [4:0] de_rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       ex_hit;
    logic       mem_hit;
    logic       wb_hit;
    logic [1:0] need;

    logic [1:0] state;
    logic [1:0] saved_state;
    logic [1:0] cur_state;
    logic [1:0] next_state;
    logic [1:0] cnt_next;
    logic       unused_bits;

    function automatic logic writer_hits(
        input logic       valid,
        input logic [6:0] op,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2
    );
        writer_hits = valid && (op != OP_BRANCH) && (op != OP_STORE) && (rd != 5'd0) &&
                      ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

    assign de_op    = de_ir[6:0];
    assign de_rs1   = de_ir[19:15];
    assign de_rs2   = de_ir[24:20];
    assign rs1_used = (de_op != OP_LUI) && (de_op != OP_AUIPC) && (de_op != OP_JAL);
    assign rs2_used = (de_op == OP_BRANCH) || (de_op == OP_STORE) || (de_op == OP_OP);

    assign ex_hit  = writer_hits(ex_valid,  ex_ir[6:0],  ex_ir[11:7],  de_rs1, de_rs2, rs1_used, rs2_used);
    assign mem_hit = writer_hits(mem_valid, mem_ir[6:0], mem_ir[11:7], de_rs1, de_rs2, rs1_used, rs2_used);
    assign wb_hit  = writer_hits(wb_valid,  wb_ir[6:0],  wb_ir[11:7],  de_rs1, de_rs2, rs1_used, rs2_used);

    assign unused_bits = ^{de_ir[31:25], de_ir[14:12], ex_ir[31:12], mem_ir[31:12], wb_ir[31:12]};

    // Closer producers always need more bubbles, so the last match wins the max
    always_comb begin
        need = 2'd0;
        if (wb_hit)  need = WB_NEED;
        if (mem_hit) need = MEM_NEED;
        if (ex_hit)  need = EX_NEED;
    end

    // Once mem_busy drops, the held state takes effect in that same cycle
    assign cur_state = (state == ST_FREEZE) ? saved_state : state;

    always_comb begin
        pc_write    = 1'b1;
        if_de_en    = 1'b1;
        if_de_clear = 1'b0;
        de_ex_clear = 1'b0;
        back_en     = 1'b1;
        next_state  = ST_RUN;
        cnt_next    = stall_cnt;
        if (rst) begin
            pc_write    = 1'b0;
            if_de_en    = 1'b0;
            if_de_clear = 1'b1;
            de_ex_clear = 1'b1;
            cnt_next    = 2'd0;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            if_de_en   = 1'b0;
            back_en    = 1'b0;
            next_state = ST_FREEZE;
        end else if (br_taken) begin
            if_de_clear = 1'b1;
            de_ex_clear = 1'b1;
            cnt_next    = 2'd0;
            next_state  = ST_FLUSH;
        end else begin
            case (cur_state)
                ST_STALL: begin
                    pc_write    = 1'b0;
                    if_de_en    = 1'b0;
                    de_ex_clear = 1'b1;
                    cnt_next    = (stall_cnt != 2'd0) ? stall_cnt - 2'd1 : 2'd0;
                    next_state  = (stall_cnt <= 2'd1) ? ST_RUN : ST_STALL;
                end
                ST_FLUSH: begin
                    cnt_next = 2'd0;
                end
                default: begin
                    cnt_next = 2'd0;
                    if (need != 2'd0) begin
                        pc_write    = 1'b0;
                        if_de_en    = 1'b0;
                        de_ex_clear = 1'b1;
                        if (need > 2'd1) begin
                            cnt_next   = need - 2'd1;
                            next_state = ST_STALL;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            stall_cnt   <= 2'd0;
        end else begin
            state     <= next_state;
            stall_cnt <= cnt_next;
            if (mem_busy && (state != ST_FREEZE))
                saved_state <= state;
        end
    end

endmodule

// File: tb/tb_otter_stall_ctrl.sv
// Directed bench for otter_stall_ctrl; runs a write-through and a
// non-write-through instance side by side on the same stimulus.
module tb_otter_stall_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // {pc_write, if_de_en, if_de_clear, de_ex_clear, back_en}
    localparam logic [4:0] RUN_O   = 5'b11001;
    localparam logic [4:0] STALL_O = 5'b00011;
    localparam logic [4:0] FLUSH_O = 5'b11111;
    localparam logic [4:0] FRZ_O   = 5'b00000;
    localparam logic [4:0] RST_O   = 5'b00111;

    logic        clk;
    logic        rst;
    logic [31:0] de_ir, ex_ir, mem_ir, wb_ir;
    logic        ex_valid, mem_valid, wb_valid, br_taken, mem_busy;

    logic        pc_write1, if_de_en1, if_de_clear1, de_ex_clear1, back_en1;
    logic [1:0]  stall_cnt1;
    logic        pc_write0, if_de_en0, if_de_clear0, de_ex_clear0, back_en0;
    logic [1:0]  stall_cnt0;

    int tests;
    int failures;

    otter_stall_ctrl #(.RF_BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .de_ir(de_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write1), .if_de_en(if_de_en1), .if_de_clear(if_de_clear1),
        .de_ex_clear(de_ex_clear1), .back_en(back_en1), .stall_cnt(stall_cnt1)
    );

    otter_stall_ctrl #(.RF_BYPASS(0)) dut0 (
        .clk(clk), .rst(rst),
        .de_ir(de_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write0), .if_de_en(if_de_en0), .if_de_clear(if_de_clear0),
        .de_ex_clear(de_ex_clear0), .back_en(back_en0), .stall_cnt(stall_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        addi = {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        add = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        lw = {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        sw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // Drive one cycle's inputs at the falling edge, then let outputs settle
    task automatic applyStimulus(
        input logic [31:0] de, input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb,
        input logic ev, input logic mv, input logic wv,
        input logic br, input logic busy, input logic r
    );
        @(negedge clk);
        de_ir = de; ex_ir = ex; mem_ir = mem; wb_ir = wb;
        ex_valid = ev; mem_valid = mv; wb_valid = wv;
        br_taken = br; mem_busy = busy; rst = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] exp1, input logic [6:0] exp0);
        logic [6:0] obs1;
        logic [6:0] obs0;
        obs1 = {pc_write1, if_de_en1, if_de_clear1, de_ex_clear1, back_en1, stall_cnt1};
        obs0 = {pc_write0, if_de_en0, if_de_clear0, de_ex_clear0, back_en0, stall_cnt0};
        tests++;
        assert (obs1 === exp1) else begin
            failures++;
            $error("[TB] FAIL %s bypass1: observed %b expected %b", tag, obs1, exp1);
        end
        tests++;
        assert (obs0 === exp0) else begin
            failures++;
            $error("[TB] FAIL %s bypass0: observed %b expected %b", tag, obs0, exp0);
        end
    endtask

    initial begin
        logic [31:0] prod5;
        logic [31:0] use5;
        tests = 0;
        failures = 0;
        rst = 1'b1;
        de_ir = NOP; ex_ir = NOP; mem_ir = NOP; wb_ir = NOP;
        ex_valid = 1'b0; mem_valid = 1'b0; wb_valid = 1'b0;
        br_taken = 1'b0; mem_busy = 1'b0;
        prod5 = addi(5'd5, 5'd0, 12'd1);
        use5  = add(5'd6, 5'd5, 5'd1);

        applyStimulus(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 0, 1);
        checkOutput("reset", {RST_O, 2'd0}, {RST_O, 2'd0});
        applyStimulus(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("idle", {RUN_O, 2'd0}, {RUN_O, 2'd0});

        // T1: EX producer, DE consumer via rs1
        applyStimulus(use5, prod5, NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t1_c1", {STALL_O, 2'd0}, {STALL_O, 2'd0});
        applyStimulus(use5, NOP, prod5, NOP, 0, 1, 0, 0, 0, 0);
        checkOutput("t1_c2", {STALL_O, 2'd1}, {STALL_O, 2'd2});
        applyStimulus(use5, NOP, NOP, prod5, 0, 0, 1, 0, 0, 0);
        checkOutput("t1_c3", {RUN_O, 2'd0}, {STALL_O, 2'd1});
        applyStimulus(NOP, use5, NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t1_c4", {RUN_O, 2'd0}, {RUN_O, 2'd0});

        // T2: load in MEM feeding store data (rs2)
        applyStimulus(sw(5'd7, 5'd2, 12'd0), NOP, lw(5'd7, 5'd2, 12'd0), NOP, 0, 1, 0, 0, 0, 0);
        checkOutput("t2_c1", {STALL_O, 2'd0}, {STALL_O, 2'd0});
        applyStimulus(sw(5'd7, 5'd2, 12'd0), NOP, NOP, lw(5'd7, 5'd2, 12'd0), 0, 0, 1, 0, 0, 0);
        checkOutput("t2_c2", {RUN_O, 2'd0}, {STALL_O, 2'd1});
        applyStimulus(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_c3", {RUN_O, 2'd0}, {RUN_O, 2'd0});

        // T3: x0 destination and a store whose imm bits alias an rd field
        applyStimulus(add(5'd6, 5'd0, 5'd0), addi(5'd0, 5'd5, 12'd1), NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t3_x0", {RUN_O, 2'd0}, {RUN_O, 2'd0});
        applyStimulus(add(5'd7, 5'd5, 5'd5), sw(5'd1, 5'd2, 12'd5), NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t3_store", {RUN_O, 2'd0}, {RUN_O, 2'd0});

        // T4: branch taken in the first bubble of a two-bubble hazard
        applyStimulus(use5, prod5, NOP, NOP, 1, 0, 0, 1, 0, 0);
        checkOutput("t4_br", {FLUSH_O, 2'd0}, {FLUSH_O, 2'd0});
        applyStimulus(use5, prod5, NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t4_flush", {RUN_O, 2'd0}, {RUN_O, 2'd0});
        applyStimulus(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_after", {RUN_O, 2'd0}, {RUN_O, 2'd0});

        // T5: memory freeze in the middle of a stall
        applyStimulus(use5, prod5, NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t5_c1", {STALL_O, 2'd0}, {STALL_O, 2'd0});
        applyStimulus(use5, NOP, prod5, NOP, 0, 1, 0, 0, 1, 0);
        checkOutput("t5_frz1", {FRZ_O, 2'd1}, {FRZ_O, 2'd2});
        applyStimulus(use5, NOP, prod5, NOP, 0, 1, 0, 1, 1, 0);
        checkOutput("t5_frz2_br", {FRZ_O, 2'd1}, {FRZ_O, 2'd2});
        applyStimulus(use5, NOP, prod5, NOP, 0, 1, 0, 0, 1, 0);
        checkOutput("t5_frz3", {FRZ_O, 2'd1}, {FRZ_O, 2'd2});
        applyStimulus(use5, NOP, prod5, NOP, 0, 1, 0, 0, 0, 0);
        checkOutput("t5_release", {STALL_O, 2'd1}, {STALL_O, 2'd2});
        applyStimulus(use5, NOP, NOP, prod5, 0, 0, 1, 0, 0, 0);
        checkOutput("t5_next", {RUN_O, 2'd0}, {STALL_O, 2'd1});
        applyStimulus(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_run", {RUN_O, 2'd0}, {RUN_O, 2'd0});

        // T6: reset aborts a stall in progress
        applyStimulus(use5, prod5, NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t6_c1", {STALL_O, 2'd0}, {STALL_O, 2'd0});
        applyStimulus(use5, NOP, prod5, NOP, 0, 1, 0, 0, 0, 1);
        checkOutput("t6_rst", {RST_O, 2'd1}, {RST_O, 2'd2});
        applyStimulus(add(5'd8, 5'd9, 5'd10), addi(5'd11, 5'd0, 12'd3), NOP, NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("t6_after", {RUN_O, 2'd0}, {RUN_O, 2'd0});
        applyStimulus(sw(5'd7, 5'd2, 12'd0), NOP, lw(5'd7, 5'd2, 12'd0), NOP, 0, 1, 0, 0, 0, 0);
        checkOutput("t6_newhaz", {STALL_O, 2'd0}, {STALL_O, 2'd0});

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
